// File: rtl/spi_slave_stream.sv
// SPI slave with oversampled SCK/SSEL/MOSI. A command word opens a read stream
// that returns a snapshot of SNAP_WORDS words, re-captured at every frame wrap.
// Every received word is also presented on rx_data/rx_valid.
module spi_slave_stream #(
    parameter int unsigned        DATA_W     = 8,
    parameter int unsigned        MODE       = 0,
    parameter logic [DATA_W-1:0]  CMD        = 8'hE0,
    parameter int unsigned        SNAP_WORDS = 8,
    parameter bit                 MISO_TRI   = 1'b1
) (
    input  logic                         clk2x,
    input  logic                         rst,
    input  logic                         sck,
    input  logic                         ssel,
    input  logic                         mosi,
    output logic                         miso,
    output logic                         miso_oe,
    input  logic [SNAP_WORDS*DATA_W-1:0] snap_in,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         rx_valid,
    output logic                         cmd_hit,
    output logic [7:0]                   frame_cnt
);

    localparam logic        CPOL  = MODE[1];
    localparam logic        CPHA  = MODE[0];
    localparam int unsigned BC_W  = $clog2(DATA_W);
    localparam int unsigned IDX_W = $clog2(SNAP_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t                         r_state;
    logic [2:0]                     r_sck_sync;
    logic [2:0]                     r_ssel_sync;
    logic [1:0]                     r_mosi_sync;
    logic [BC_W-1:0]                r_bitcnt;
    logic [DATA_W-2:0]              r_shift;
    logic [DATA_W-1:0]              r_tx_sr;
    logic [SNAP_WORDS*DATA_W-1:0]   r_snap_reg;
    logic [IDX_W-1:0]               r_word_idx;
    logic                           r_load_pending;
    logic                           r_miso_oe;
    logic [DATA_W-1:0]              r_rx_data;
    logic                           r_rx_valid;
    logic                           r_cmd_hit;
    logic [7:0]                     r_frame_cnt;

    logic [1:0]                     w_sck_n;
    logic                           w_lead;
    logic                           w_trail;
    logic                           w_sample_edge;
    logic                           w_shift_edge;
    logic                           w_ssel_act;
    logic                           w_ssel_fall;
    logic [DATA_W-1:0]              w_word;
    logic [DATA_W-1:0]              w_snap_words [SNAP_WORDS];
    logic [DATA_W-1:0]              w_snap_word;

    // Bring the asynchronous SPI pins into the clk2x domain
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= {3{CPOL}};
            r_ssel_sync <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], sck};
            r_ssel_sync <= {r_ssel_sync[1:0], ssel};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
        end
    end

    // SCK normalised by CPOL so lead is always a rising transition
    assign w_sck_n       = r_sck_sync[2:1] ^ {2{CPOL}};
    assign w_lead        = ~w_sck_n[1] &  w_sck_n[0];
    assign w_trail       =  w_sck_n[1] & ~w_sck_n[0];
    assign w_sample_edge = CPHA ? w_trail : w_lead;
    assign w_shift_edge  = CPHA ? w_lead  : w_trail;
    assign w_ssel_act    = ~r_ssel_sync[1];
    assign w_ssel_fall   = r_ssel_sync[2] & ~r_ssel_sync[1];
    assign w_word        = {r_shift, r_mosi_sync[1]};

    // Word 0 of the snapshot is the most significant slice of snap_in
    for (genvar g = 0; g < SNAP_WORDS; g++) begin : g_snap
        assign w_snap_words[g] = r_snap_reg[(SNAP_WORDS-1-g)*DATA_W +: DATA_W];
    end
    assign w_snap_word = w_snap_words[r_word_idx];

    // Protocol FSM: receive shifting, command decode, stream transmit, framing
    always_ff @(posedge clk2x or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_bitcnt       <= '0;
            r_shift        <= '0;
            r_tx_sr        <= '0;
            r_snap_reg     <= '0;
            r_word_idx     <= '0;
            r_load_pending <= 1'b0;
            r_miso_oe      <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_cmd_hit      <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            r_cmd_hit  <= 1'b0;
            // Deselect has priority over any SCK edge seen in the same clk
            if (!w_ssel_act) begin
                r_state        <= ST_IDLE;
                r_miso_oe      <= 1'b0;
                r_bitcnt       <= '0;
                r_load_pending <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_ssel_fall) begin
                    r_state  <= ST_CMD;
                    r_bitcnt <= '0;
                end
            end else begin
                if (w_sample_edge) begin
                    r_shift <= w_word[DATA_W-2:0];
                    if (r_bitcnt == BC_W'(DATA_W-1)) begin
                        r_bitcnt   <= '0;
                        r_rx_data  <= w_word;
                        r_rx_valid <= 1'b1;
                        if (r_state == ST_CMD) begin
                            if (w_word == CMD) begin
                                r_state        <= ST_STREAM;
                                r_miso_oe      <= 1'b1;
                                r_cmd_hit      <= 1'b1;
                                r_snap_reg     <= snap_in;
                                r_word_idx     <= '0;
                                r_load_pending <= 1'b1;
                            end else begin
                                r_state <= ST_DRAIN;
                            end
                        end else if (r_state == ST_STREAM) begin
                            r_load_pending <= 1'b1;
                            if (r_word_idx == IDX_W'(SNAP_WORDS-1)) begin
                                r_word_idx  <= '0;
                                r_frame_cnt <= r_frame_cnt + 8'd1;
                                r_snap_reg  <= snap_in;
                            end else begin
                                r_word_idx <= r_word_idx + IDX_W'(1);
                            end
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + BC_W'(1);
                    end
                end
                if (w_shift_edge && (r_state == ST_STREAM)) begin
                    if (r_load_pending) begin
                        r_tx_sr        <= w_snap_word;
                        r_load_pending <= 1'b0;
                    end else begin
                        r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign miso      = r_miso_oe ? r_tx_sr[DATA_W-1] : (MISO_TRI ? 1'bz : 1'b0);
    assign miso_oe   = r_miso_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign cmd_hit   = r_cmd_hit;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Bench for spi_slave_stream: one instance per SPI mode, driven by a
// behavioural master; received words are checked through a scoreboard queue.
module tb_spi_slave_stream;

    localparam int          HALF   = 8;
    localparam logic [63:0] SNAP_A = 64'h0102030405060708;
    localparam logic [63:0] SNAP_B = 64'hF1E2D3C4B5A69788;

    logic        clk2x = 1'b0;
    logic        rst;
    logic [3:0]  sck;
    logic [3:0]  ssel;
    logic        mosi;
    wire  [3:0]  miso;
    logic [3:0]  miso_oe;
    logic [63:0] snap_in;
    logic [7:0]  rx_data   [4];
    logic [3:0]  rx_valid;
    logic [3:0]  cmd_hit;
    logic [7:0]  frame_cnt [4];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cur_m = 0;
    int          hit_cnt [4] = '{default: 0};
    int          rxv_cnt [4] = '{default: 0};
    int          oe_cycles = 0;
    int          exp_fc  [4] = '{default: 0};
    logic [7:0]  q_rx   [$];
    logic [7:0]  q_miso [$];

    always #5 clk2x = ~clk2x;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_stream #(
            .DATA_W     (8),
            .MODE       (g),
            .CMD        (8'hE0),
            .SNAP_WORDS (8),
            .MISO_TRI   (1'b1)
        ) u_dut (
            .clk2x     (clk2x),
            .rst       (rst),
            .sck       (sck[g]),
            .ssel      (ssel[g]),
            .mosi      (mosi),
            .miso      (miso[g]),
            .miso_oe   (miso_oe[g]),
            .snap_in   (snap_in),
            .rx_data   (rx_data[g]),
            .rx_valid  (rx_valid[g]),
            .cmd_hit   (cmd_hit[g]),
            .frame_cnt (frame_cnt[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] snap_word(input logic [63:0] s, input int idx);
        return s[(7-idx)*8 +: 8];
    endfunction

    // Output monitor: rx scoreboard and event counters
    always @(negedge clk2x) begin
        if (miso_oe[cur_m]) oe_cycles++;
        for (int m = 0; m < 4; m++) begin
            if (cmd_hit[m]) hit_cnt[m]++;
            if (rx_valid[m]) begin
                rxv_cnt[m]++;
                if (m != cur_m) check("rx_inst", m, cur_m);
                else if (q_rx.size() == 0) check("rx_extra", q_rx.size(), 1);
                else check("rx_data", {24'h0, rx_data[m]}, {24'h0, q_rx.pop_front()});
            end
        end
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clk2x);
    endtask

    task automatic sel(input int m);
        ssel[m] = 1'b0;
        wait_half();
    endtask

    task automatic desel(input int m, input int gap);
        wait_half();
        ssel[m] = 1'b1;
        repeat (gap) @(negedge clk2x);
    endtask

    task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        logic cpol;
        logic cpha;
        cpol = (m & 2) != 0;
        cpha = (m & 1) != 0;
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                wait_half();
                rx[i] = miso[m];
                sck[m] = ~cpol;
                wait_half();
                sck[m] = cpol;
            end else begin
                sck[m] = ~cpol;
                mosi = tx[i];
                wait_half();
                rx[i] = miso[m];
                sck[m] = cpol;
                wait_half();
            end
        end
    endtask

    task automatic word(input int m, input logic [7:0] tx, input logic [7:0] exp_miso,
                        input bit cmp_miso, input string tag);
        logic [7:0] got;
        q_rx.push_back(tx);
        if (cmp_miso) q_miso.push_back(exp_miso);
        xfer(m, tx, 8, got);
        if (cmp_miso) check(tag, {24'h0, got}, {24'h0, q_miso.pop_front()});
    endtask

    task automatic run_stream(input int m, input string tag);
        int h0;
        int r0;
        h0 = hit_cnt[m];
        r0 = rxv_cnt[m];
        cur_m = m;
        snap_in = SNAP_A;
        sel(m);
        word(m, 8'hE0, 8'h00, 1'b0, tag);
        for (int k = 0; k < 8; k++)
            word(m, 8'(8'h3C + k * 17), snap_word(SNAP_A, k), 1'b1, {tag, "_miso"});
        desel(m, 4);
        exp_fc[m]++;
        check({tag, "_hit"}, hit_cnt[m] - h0, 1);
        check({tag, "_fc"}, {24'h0, frame_cnt[m]}, exp_fc[m]);
        check({tag, "_rxv"}, rxv_cnt[m] - r0, 9);
    endtask

    task automatic check_reset(input int m, input string tag);
        check({tag, "_oe"},  {31'h0, miso_oe[m]}, 0);
        check({tag, "_rxd"}, {24'h0, rx_data[m]}, 0);
        check({tag, "_rxv"}, {31'h0, rx_valid[m]}, 0);
        check({tag, "_hit"}, {31'h0, cmd_hit[m]}, 0);
        check({tag, "_fc"},  {24'h0, frame_cnt[m]}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         h0;
        int         r0;
        int         o0;
        logic [7:0] got;
        logic [7:0] exp_b;

        rst     = 1'b1;
        ssel    = '1;
        sck     = 4'b1100;
        mosi    = 1'b0;
        snap_in = '0;
        repeat (4) @(negedge clk2x);
        for (int m = 0; m < 4; m++) check_reset(m, "rst");
        rst = 1'b0;
        repeat (4) @(negedge clk2x);

        // T1: mode 0 stream
        run_stream(0, "t1");

        // T2: non-command word drains
        cur_m = 0;
        o0 = oe_cycles;
        h0 = hit_cnt[0];
        r0 = rxv_cnt[0];
        sel(0);
        word(0, 8'h55, 8'h00, 1'b0, "t2");
        for (int k = 0; k < 4; k++) word(0, 8'($urandom_range(0, 255)), 8'h00, 1'b0, "t2");
        desel(0, 4);
        check("t2_oe", oe_cycles - o0, 0);
        check("t2_hit", hit_cnt[0] - h0, 0);
        check("t2_rxv", rxv_cnt[0] - r0, 5);
        check("t2_fc", {24'h0, frame_cnt[0]}, exp_fc[0]);

        // T3: remaining modes
        for (int m = 1; m < 4; m++) run_stream(m, $sformatf("t3m%0d", m));

        // T4: two frames with snapshot change in the first
        cur_m = 0;
        h0 = hit_cnt[0];
        snap_in = SNAP_A;
        sel(0);
        word(0, 8'hE0, 8'h00, 1'b0, "t4");
        for (int k = 0; k < 17; k++) begin
            exp_b = (k < 8) ? snap_word(SNAP_A, k % 8) : snap_word(SNAP_B, k % 8);
            word(0, 8'(k), exp_b, 1'b1, "t4_miso");
            if (k == 3) snap_in = SNAP_B;
        end
        desel(0, 4);
        exp_fc[0] += 2;
        check("t4_fc", {24'h0, frame_cnt[0]}, exp_fc[0]);
        check("t4_hit", hit_cnt[0] - h0, 1);

        // T5: abort mid-word, then back-to-back reselect
        snap_in = SNAP_A;
        h0 = hit_cnt[0];
        r0 = rxv_cnt[0];
        sel(0);
        word(0, 8'hE0, 8'h00, 1'b0, "t5");
        for (int k = 0; k < 3; k++) word(0, 8'(8'hC0 + k), snap_word(SNAP_A, k), 1'b1, "t5_miso");
        xfer(0, 8'hA5, 5, got);
        desel(0, 1);
        check("t5_rxv", rxv_cnt[0] - r0, 4);
        check("t5_fc", {24'h0, frame_cnt[0]}, exp_fc[0]);
        sel(0);
        word(0, 8'hE0, 8'h00, 1'b0, "t5");
        word(0, 8'h11, snap_word(SNAP_A, 0), 1'b1, "t5_restart");
        word(0, 8'h22, snap_word(SNAP_A, 1), 1'b1, "t5_restart");
        desel(0, 4);
        check("t5_hit", hit_cnt[0] - h0, 2);

        // T6: reset mid-word in stream
        sel(0);
        word(0, 8'hE0, 8'h00, 1'b0, "t6");
        word(0, 8'h5A, snap_word(SNAP_A, 0), 1'b1, "t6_miso");
        check("t6_oe_pre", {31'h0, miso_oe[0]}, 1);
        check("t6_fc_pre", {24'h0, frame_cnt[0]}, exp_fc[0]);
        xfer(0, 8'h96, 4, got);
        rst = 1'b1;
        @(negedge clk2x);
        check_reset(0, "t6");
        for (int m = 0; m < 4; m++) exp_fc[m] = 0;
        rst = 1'b0;
        desel(0, 4);
        run_stream(0, "t6_rec");

        check("q_rx_empty", q_rx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
